viterbi_survivor_unit: RTL and testbench
========================================

Name: viterbi_survivor_unit

Overview:
- Parametrised register-exchange survivor/decision unit for the Viterbi decoder. Generalises the fixed 4-state, TBL=15 traceback unit to any constraint length, traceback depth and path-metric width.
- Adds frame termination: when the last step of a frame is accepted, the unit flushes the remaining survivor bits.
- Sits after the ACS/path-metric block and emits decoded bits to the deframer.

Parameters:
- K, 3, constraint length; M=K-1 memory bits, NS=2^M states.
- TBL, 15, survivor depth in bits (>=2).
- PM_W, 8, path-metric width (unsigned, already normalised upstream).
- TERMINATED, 1, at frame end: 1 = flush from state 0, 0 = flush from the best-metric state.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_i  in  1  trellis step present.
- ready_o  out  1  step accepted when valid_i & ready_o.
- last_i  in  1  this step is the frame's final step; qualified by acceptance.
- dec_bits_i  in  NS  ACS decision per state; bit s=0 selects predecessor {s[M-2:0],0}, 1 selects {s[M-2:0],1}.
- pm_i  in  NS*PM_W  new path metrics; state s at [s*PM_W +: PM_W].
- decoded_bit_o  out  1  decoded bit.
- valid_o  out  1  decoded_bit_o valid this cycle (single-cycle pulse per bit).
- last_o  out  1  final decoded bit of the frame.

Behaviour:
- Reset: all survivors 0; fill_cnt 0; FSM=RUN; valid_o, decoded_bit_o, last_o = 0. ready_o = (FSM==RUN), so it is 1 during and after reset.
- Input bit of state s is s[M-1] (MSB).
- Register exchange on each accepted step: surv[s] <= {surv[pred(s)][TBL-2:0], s[M-1]}. No acceptance means no survivor or counter change, and valid_o=0 the next cycle.
- Best state: argmin of pm_i over all NS states, unsigned compare. Ties go to the lowest index. Purely combinational on the current inputs.
- fill_cnt counts accepted steps and saturates at TBL. Width is clog2(TBL+1).
- RUN output, at the edge of accepted step n:
  - if n >= TBL: valid_o <= 1 and decoded_bit_o <= surv_next[best][TBL-1], i.e. the bit decided at step n-TBL+1. Latency is TBL-1 accepted steps after the decision.
  - otherwise valid_o <= 0.
- Frame end: an accepted step with last_i=1 produces its normal RUN output (if n >= TBL), then:
  - flush_sr <= surv_next[sel], where sel = 0 if TERMINATED else best;
  - flush_cnt <= min(n, TBL-1);
  - FSM -> FLUSH.
- FLUSH:
  - ready_o=0; valid_i, last_i, dec_bits_i and pm_i are ignored.
  - Each cycle: valid_o=1, decoded_bit_o = next-oldest bit of flush_sr (shift toward the MSB end), flush_cnt decrements.
  - last_o=1 with the bit where flush_cnt reaches 0 (i.e. when flush_cnt was 1).
  - On the cycle after last_o: FSM -> RUN; survivors and fill_cnt are cleared at that same edge.
- Frame of length 1: flush emits exactly 1 bit with last_o=1.
- Frame length n < TBL: no RUN outputs; flush emits n bits, oldest first.
- Total decoded bits per frame always equals the number of accepted steps.
- Reset asserted mid-frame or mid-flush: immediate return to reset values; the partial frame is discarded with no last_o.
- last_o is only ever high together with valid_o.

Decomposition:
- Package viterbi_pkg holds:
  - FSM enum {RUN, FLUSH};
  - functions n_states(K) and pred_idx(s, d, M);
  - a clog2 helper.
- Sub-module best_state_sel: parametrised (NS, PM_W) argmin tree with lowest-index tie-break, outputting a clog2(NS)-bit index.

Test Plan (K=3, TBL=15, PM_W=8 unless noted):
- Reset: rst_n low 15 ns -> valid_o=0, last_o=0, ready_o=1.
- Fill latency: 15 accepted steps, dec_bits_i=0000, pm={0,10,10,10} -> valid_o first 1 after the 15th edge with bit 0. No valid_o on edges 1-14.
- Register exchange: 16 steps of dec_bits_i=0100, pm_s2=0, others 10 -> output on step 16 is 1. A switch to pm_s3=0 outputs surv[3]'s oldest bit; equal pm_s1=pm_s2=0 selects state 1.
- Gating: drop valid_i for 3 cycles mid-stream -> valid_o=0 for those cycles; the bit sequence resumes unchanged.
- Flush: 20 steps with last_i on step 20 -> 6 RUN bits, then ready_o=0 for 14 cycles emitting 14 bits, last_o on the 14th. The next frame's first output needs 15 new steps.
- Short frame and reset: a 5-step frame gives 0 RUN bits and 5 flush bits. Reset asserted during flush -> all outputs 0 at once, no last_o. Repeat the fill test with K=4, TBL=20 (latency 20 steps).

Source files
------------

// File: rtl/viterbi_survivor_unit_pkg.sv
// Shared types and elaboration-time helpers for the Viterbi survivor unit.
package viterbi_pkg;

  typedef enum logic {RUN, FLUSH} fsm_t;

  // ceil(log2(v)), with clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned n_states(input int unsigned k);
    return 32'd1 << (k - 1);
  endfunction

  // Predecessor of state s given ACS decision d: {s[m-2:0], d}
  function automatic int unsigned pred_idx(input int unsigned s, input logic d,
                                           input int unsigned m);
    return ((s << 1) | {31'b0, d}) & ((32'd1 << m) - 1);
  endfunction

endpackage

// File: rtl/viterbi_survivor_unit_if.sv
// Trellis-step input and decoded-bit output bus of the survivor unit.
interface viterbi_survivor_unit_if #(
  parameter int unsigned NS   = 4,
  parameter int unsigned PM_W = 8
);
  logic             valid_i;
  logic             ready_o;
  logic             last_i;
  logic [NS-1:0]    dec_bits_i;
  logic [NS*PM_W-1:0] pm_i;
  logic             decoded_bit_o;
  logic             valid_o;
  logic             last_o;

  modport master (
    output valid_i, last_i, dec_bits_i, pm_i,
    input  ready_o, decoded_bit_o, valid_o, last_o
  );

  modport slave (
    input  valid_i, last_i, dec_bits_i, pm_i,
    output ready_o, decoded_bit_o, valid_o, last_o
  );
endinterface

// File: rtl/viterbi_survivor_unit_best.sv
// Argmin over NS unsigned path metrics; ties resolve to the lowest index.
module best_state_sel
  import viterbi_pkg::*;
#(
  parameter int unsigned NS   = 4,
  parameter int unsigned PM_W = 8,
  localparam int unsigned IDX_W = clog2(NS)
) (
  input  logic [NS*PM_W-1:0] pm,
  output logic [IDX_W-1:0]   best
);

  logic [PM_W-1:0] best_pm;

  // Strict less-than keeps the earlier (lower) index on equal metrics
  always_comb begin
    best    = '0;
    best_pm = pm[PM_W-1:0];
    for (int unsigned s = 1; s < NS; s++) begin
      if (pm[s*PM_W +: PM_W] < best_pm) begin
        best_pm = pm[s*PM_W +: PM_W];
        best    = IDX_W'(s);
      end
    end
  end

endmodule

// File: rtl/viterbi_survivor_unit.sv
// Register-exchange survivor memory with frame-end flush of pending bits.
module viterbi_survivor_unit
  import viterbi_pkg::*;
#(
  parameter int unsigned K          = 3,
  parameter int unsigned TBL        = 15,
  parameter int unsigned PM_W       = 8,
  parameter bit          TERMINATED = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  viterbi_survivor_unit_if.slave bus
);

  localparam int unsigned M     = K - 1;
  localparam int unsigned NS    = n_states(K);
  localparam int unsigned IDX_W = clog2(NS);
  localparam int unsigned CNT_W = clog2(TBL + 1);

  fsm_t             state, state_next;
  logic [TBL-1:0]   surv      [NS];
  logic [TBL-1:0]   surv_next [NS];
  logic [CNT_W-1:0] fill_cnt, fill_next, flush_cnt, flush_load;
  logic [TBL-1:0]   flush_sr;
  logic [IDX_W-1:0] best, sel;
  logic             ready, accept;
  logic             valid_q, bit_q, last_q;

  best_state_sel #(.NS(NS), .PM_W(PM_W)) u_best (
    .pm   (bus.pm_i),
    .best (best)
  );

  assign accept        = bus.valid_i & ready;
  assign sel           = TERMINATED ? '0 : best;
  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid_q;
  assign bus.decoded_bit_o = bit_q;
  assign bus.last_o    = last_q;

  // Each state's survivor extends its chosen predecessor with the state's input bit (MSB)
  always_comb begin
    logic [IDX_W-1:0] p;
    logic             in_bit;
    for (int unsigned s = 0; s < NS; s++) begin
      p            = IDX_W'(pred_idx(s, bus.dec_bits_i[s], M));
      in_bit       = 1'(s >> (M - 1));
      surv_next[s] = (surv[p] << 1) | {{(TBL-1){1'b0}}, in_bit};
    end
  end

  // Saturating step count and number of not-yet-emitted bits at frame end
  always_comb begin
    fill_next  = (fill_cnt == CNT_W'(TBL)) ? fill_cnt : fill_cnt + 1'b1;
    flush_load = (fill_next == CNT_W'(TBL)) ? CNT_W'(TBL - 1) : fill_next;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // FSM next-state: enter FLUSH on accepted last step, leave on the final flushed bit
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept && bus.last_i) state_next = FLUSH;
      FLUSH:   if (flush_cnt == CNT_W'(1)) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = (state == RUN);
  end

  // Survivor update, RUN decisions and flush shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NS; s++) surv[s] <= '0;
      fill_cnt  <= '0;
      flush_cnt <= '0;
      flush_sr  <= '0;
      valid_q   <= 1'b0;
      bit_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      if (state == RUN) begin
        if (accept) begin
          for (int unsigned s = 0; s < NS; s++) surv[s] <= surv_next[s];
          fill_cnt <= fill_next;
          if (fill_next == CNT_W'(TBL)) begin
            valid_q <= 1'b1;
            bit_q   <= surv_next[best][TBL-1];
          end
          // Left-align the pending bits so the oldest one sits at the MSB
          if (bus.last_i) begin
            flush_sr  <= surv_next[sel] << (CNT_W'(TBL) - flush_load);
            flush_cnt <= flush_load;
          end
        end
      end else begin
        valid_q   <= 1'b1;
        bit_q     <= flush_sr[TBL-1];
        flush_sr  <= flush_sr << 1;
        flush_cnt <= flush_cnt - 1'b1;
        if (flush_cnt == CNT_W'(1)) begin
          last_q   <= 1'b1;
          for (int unsigned s = 0; s < NS; s++) surv[s] <= '0;
          fill_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_survivor_unit.sv
// Directed bench for the survivor unit: K=3/TBL=15 and K=4/TBL=20 instances.
module tb_viterbi_survivor_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  viterbi_survivor_unit_if #(.NS(4), .PM_W(8)) bus3 ();
  viterbi_survivor_unit_if #(.NS(8), .PM_W(8)) bus4 ();

  viterbi_survivor_unit #(.K(3), .TBL(15), .PM_W(8), .TERMINATED(1'b1)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  viterbi_survivor_unit #(.K(4), .TBL(20), .PM_W(8), .TERMINATED(1'b1)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pm3(input int unsigned b);
    logic [31:0] pm;
    pm = {4{8'd10}};
    pm[b*8 +: 8] = 8'd0;
    return pm;
  endfunction

  // Drive one cycle on the K=3 bus, then sample 1 ns after the edge
  task automatic step3(input logic v, input logic l, input logic [3:0] dec, input logic [31:0] pm);
    bus3.valid_i    = v;
    bus3.last_i     = l;
    bus3.dec_bits_i = dec;
    bus3.pm_i       = pm;
    @(posedge clk);
    #1;
  endtask

  task automatic idle3();
    bus3.valid_i    = 1'b0;
    bus3.last_i     = 1'b0;
    bus3.dec_bits_i = '0;
    bus3.pm_i       = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [13:0] exp_fl;
    logic [4:0]  exp_sh;
    int          run_bits;

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle3();
    bus4.valid_i    = 1'b0;
    bus4.last_i     = 1'b0;
    bus4.dec_bits_i = '0;
    bus4.pm_i       = '0;

    // reset values
    #12;
    check_eq("rst_valid", bus3.valid_o, 1'b0);
    check_eq("rst_last",  bus3.last_o,  1'b0);
    check_eq("rst_ready", bus3.ready_o, 1'b1);
    check_eq("rst_ready4", bus4.ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // fill latency: first output exactly on the 15th accepted step
    for (int k = 1; k <= 15; k++) begin
      step3(1'b1, 1'b0, 4'b0000, pm3(0));
      check_eq("fill_valid", bus3.valid_o, (k == 15));
      if (k == 15) check_eq("fill_bit", bus3.decoded_bit_o, 1'b0);
    end
    idle3();
    do_reset();

    // register exchange along the 2->1->2 loop
    for (int k = 1; k <= 16; k++) begin
      step3(1'b1, 1'b0, 4'b0100, pm3(2));
      check_eq("xchg_valid", bus3.valid_o, (k >= 15));
      if (k >= 15) check_eq("xchg_bit_s2", bus3.decoded_bit_o, 1'b1);
    end
    step3(1'b1, 1'b0, 4'b0100, pm3(3));
    check_eq("xchg_bit_s3", bus3.decoded_bit_o, 1'b0);
    step3(1'b1, 1'b0, 4'b0100, {8'd10, 8'd0, 8'd0, 8'd10});
    check_eq("tie_bit_s1", bus3.decoded_bit_o, 1'b0);
    step3(1'b1, 1'b0, 4'b0100, pm3(2));
    check_eq("xchg_bit_s2b", bus3.decoded_bit_o, 1'b1);

    // gating: no acceptance for 3 cycles
    for (int g = 0; g < 3; g++) begin
      step3(1'b0, 1'b0, 4'b1111, pm3(3));
      check_eq("gap_valid", bus3.valid_o, 1'b0);
      check_eq("gap_ready", bus3.ready_o, 1'b1);
    end
    step3(1'b1, 1'b0, 4'b0100, pm3(2));
    check_eq("resume_valid", bus3.valid_o, 1'b1);
    check_eq("resume_bit_s2", bus3.decoded_bit_o, 1'b1);
    step3(1'b1, 1'b0, 4'b0100, pm3(3));
    check_eq("resume_bit_s3", bus3.decoded_bit_o, 1'b0);
    idle3();
    do_reset();

    // 20-step frame: 6 RUN bits, then 14 flush bits from state 0
    run_bits = 0;
    for (int k = 1; k <= 20; k++) begin
      step3(1'b1, (k == 20), (k == 20) ? 4'b0101 : 4'b0100, pm3(2));
      check_eq("frame_valid", bus3.valid_o, (k >= 15));
      if (bus3.valid_o) run_bits++;
      if (k >= 15) check_eq("frame_bit", bus3.decoded_bit_o, 1'b1);
    end
    check_eq("run_bits", run_bits, 6);
    exp_fl = 14'b01010101010100;
    for (int i = 0; i < 14; i++) begin
      check_eq("flush_ready", bus3.ready_o, 1'b0);
      step3((i < 13), 1'b1, 4'b1111, pm3(1));
      check_eq("flush_valid", bus3.valid_o, 1'b1);
      check_eq("flush_bit",   bus3.decoded_bit_o, exp_fl[13-i]);
      check_eq("flush_last",  bus3.last_o, (i == 13));
    end
    idle3();
    check_eq("post_flush_ready", bus3.ready_o, 1'b1);
    // next frame needs a fresh fill
    for (int k = 1; k <= 15; k++) begin
      step3(1'b1, 1'b0, 4'b0000, pm3(0));
      check_eq("refill_valid", bus3.valid_o, (k == 15));
      check_eq("refill_last",  bus3.last_o, 1'b0);
    end
    idle3();
    do_reset();

    // short frame: 5 steps, no RUN bits, 5 flush bits oldest first
    exp_sh = 5'b10100;
    for (int k = 1; k <= 5; k++) begin
      step3(1'b1, (k == 5), (k == 5) ? 4'b0101 : 4'b0100, pm3(2));
      check_eq("short_valid", bus3.valid_o, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      check_eq("short_ready", bus3.ready_o, 1'b0);
      step3(1'b0, 1'b0, 4'b0000, pm3(0));
      check_eq("short_fvalid", bus3.valid_o, 1'b1);
      check_eq("short_fbit",   bus3.decoded_bit_o, exp_sh[4-i]);
      check_eq("short_flast",  bus3.last_o, (i == 4));
    end
    check_eq("short_ready_end", bus3.ready_o, 1'b1);

    // reset asserted in the middle of a flush
    for (int k = 1; k <= 5; k++)
      step3(1'b1, (k == 5), (k == 5) ? 4'b0101 : 4'b0100, pm3(2));
    for (int i = 0; i < 2; i++) begin
      step3(1'b0, 1'b0, 4'b0000, pm3(0));
      check_eq("pre_rst_fbit", bus3.decoded_bit_o, exp_sh[4-i]);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", bus3.valid_o, 1'b0);
    check_eq("midrst_last",  bus3.last_o,  1'b0);
    check_eq("midrst_bit",   bus3.decoded_bit_o, 1'b0);
    check_eq("midrst_ready", bus3.ready_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("inrst_valid", bus3.valid_o, 1'b0);
      check_eq("inrst_last",  bus3.last_o,  1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // K=4, TBL=20 fill latency
    for (int k = 1; k <= 20; k++) begin
      bus4.valid_i    = 1'b1;
      bus4.last_i     = 1'b0;
      bus4.dec_bits_i = 8'h00;
      bus4.pm_i       = {{7{8'd10}}, 8'd0};
      @(posedge clk);
      #1;
      check_eq("k4_fill_valid", bus4.valid_o, (k == 20));
      if (k == 20) check_eq("k4_fill_bit", bus4.decoded_bit_o, 1'b0);
    end
    bus4.valid_i = 1'b0;
    @(posedge clk);
    #1;
    check_eq("k4_idle_valid", bus4.valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
